// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and zero-gap back-to-back frames.
// Optional trailing even-parity bit is enabled by defining PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic {IDLE, SHIFT} state_e;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef PARITY_EN
  logic               par_q, par_d;
`endif

  logic               last_bit;
  logic               accept;
  logic               head_bit;
  logic [WIDTH-1:0]   shreg_shifted;

  assign last_bit      = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign accept        = load_valid && load_ready;
  assign head_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  // Outputs are decoded from registered state so an async reset clears them at once.
  always_comb begin
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
`ifdef PARITY_EN
    load_ready  = (state_q == IDLE) || (state_q == PARITY);
`else
    load_ready  = (state_q == IDLE) || last_bit;
`endif
    case (state_q)
      SHIFT: begin
        sout        = head_bit;
        sout_valid  = 1'b1;
        frame_start = (cnt_q == '0);
`ifndef PARITY_EN
        done        = last_bit;
`endif
      end
`ifdef PARITY_EN
      PARITY: begin
        sout       = par_q;
        sout_valid = 1'b1;
        done       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // An accept can only occur in cycles where load_ready is high, so it takes priority.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      shreg_d = load_data;
      cnt_d   = '0;
`ifdef PARITY_EN
      par_d   = ^load_data;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q != LAST_CNT) begin
            cnt_d   = cnt_q + CNT_W'(1);
            shreg_d = shreg_shifted;
          end else begin
            shreg_d = '0;
            cnt_d   = '0;
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef PARITY_EN
        PARITY: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
